spi_reg_responder: RTL and testbench
====================================

SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

Interface
REQ-001 clk  input  1  system clock; all state is in this single domain.
REQ-002 rst_n  input  1  asynchronous active-low reset; synchronous deassertion is provided externally.
REQ-003 ena  input  1  design enable; while 0, frames are ignored, miso_oe=0 and registers hold their values.
REQ-004 sclk  input  1  host serial clock, SPI mode 0, frequency at most clk/6.
REQ-005 cs_n  input  1  active-low frame select.
REQ-006 mosi  input  1  host-to-chip data, MSB first.
REQ-007 miso  output  1  chip-to-host data, MSB first.
REQ-008 miso_oe  output  1  pad output enable for miso.
REQ-009 cfg  output  32  {cfg3,cfg2,cfg1,cfg0}, the analog trim/config registers.
REQ-010 status_in  input  8  analog status bits, readable at address 4.
REQ-011 frame_err  output  1  sticky flag, set when a frame is aborted.

Function
REQ-012 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized sclk.
REQ-013 Frame: 16 bits. Bit15 is R/W (1=write), bits14:8 are address, bits7:0 are data.
REQ-014 mosi SHALL be sampled on each synchronized sclk rising edge while synced cs_n=0 and ena=1.
REQ-015 Bit counter: 0..16. Cleared on synced cs_n falling edge. Saturates at 16. Bits after the 16th are ignored.
REQ-016 Write: on the 16th rising edge, if R/W=1 and address is 0..3, the addressed cfg byte SHALL update on the following clk cycle.
REQ-017 Write commit: writes to addresses 4..127 SHALL be discarded; a read frame SHALL never modify cfg.
REQ-018 Read setup: on the 8th rising edge, if R/W=0, the tx shift register SHALL load the read value.
REQ-019 Read map: 0..3 gives cfg0..cfg3; 4 gives status_in, sampled at load time; 5 gives frame_cnt; all others give 0x00.
REQ-020 frame_cnt SHALL be an 8-bit count of completed 16-bit frames. It wraps 0xFF->0x00 and is incremented at commit.
REQ-021 Read output: miso SHALL present tx bit7 starting at the sclk falling edge after the 8th rising edge, then shift one bit per falling edge.
REQ-022 miso SHALL be 0 whenever it is not driving read data.
REQ-023 miso_oe SHALL equal (synced cs_n==0) AND ena.
REQ-024 Abort: if synced cs_n rises with the bit count in 1..15, no write occurs, frame_cnt is unchanged and frame_err is set to 1.
REQ-025 frame_err SHALL be cleared only by reset or by a write of any data to address 7.
REQ-026 Address 7 is not otherwise stored and reads as 0x00.
REQ-027 cs_n rising with a bit count of 0 or 16 SHALL NOT set frame_err.
REQ-028 cs_n falling and an sclk rising edge in the same synchronized cycle: the counter clears first and that edge is not sampled.
REQ-029 ena falling mid-frame SHALL be treated as an abort (REQ-024).
REQ-030 After ena falls mid-frame, the next frame begins only on a new cs_n falling edge.

Reset
REQ-031 While rst_n=0, the following SHALL be 0: cfg, frame_cnt, frame_err, miso, miso_oe, bit counter, shift registers.
REQ-032 While rst_n=0, synchronizer flops SHALL be 1 for cs_n and 0 for sclk and mosi.
REQ-033 Reset asserted mid-frame SHALL discard the frame without setting frame_err.
REQ-034 After reset release, a frame SHALL be accepted only after a fresh cs_n falling edge.

Verification
REQ-035 Write 0x81 0x5A (write, addr 1, data 0x5A) -> cfg[15:8]=0x5A, other bytes 0, frame_cnt=1, frame_err=0.
REQ-036 After REQ-035, read 0x01 0x00 -> miso returns 0x5A over bits 8..15, miso_oe=1 during the frame, cfg unchanged, frame_cnt=2.
REQ-037 status_in=0xC3, read addr 4 -> 0xC3. Read addr 9 -> 0x00. Write 0x84 0xFF -> cfg unchanged.
REQ-038 Raise cs_n after 10 bits of a write to addr 0 -> cfg0 unchanged, frame_err=1, frame_cnt unchanged.
REQ-039 After REQ-038, write 0x87 0x00 -> frame_err=0.
REQ-040 Run 256 complete frames -> frame_cnt wraps to its starting value.
REQ-041 Assert rst_n=0 at bit 12 of a write -> all outputs 0, frame_err=0.
REQ-042 After REQ-041, a subsequent full write succeeds.

Source files
------------

// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder: four cfg bytes, status and frame counter.
// Host signals are synchronized into clk; all framing runs on clk.
module spi_reg_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [31:0] cfg,
  input  logic [7:0]  status_in,
  output logic        frame_err
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_q;
  logic [2:0]  cs_q;
  logic [1:0]  mosi_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [14:0] rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        rd_q, rd_d;
  logic        miso_q, miso_d;
  logic [31:0] cfg_q, cfg_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        err_q, err_d;

  logic        sclk_rise, sclk_fall;
  logic        cs_fall, cs_rise;
  logic        mid;
  logic [15:0] word;
  logic [7:0]  rd_val;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign mid       = (cnt_q != 5'd0) && (cnt_q != 5'd16);
  assign word      = {rx_q, mosi_q[1]};

  // word[6:0] is the address once the 8th bit is in
  always_comb begin
    rd_val = 8'h00;
    unique case (word[6:0])
      7'd0:    rd_val = cfg_q[7:0];
      7'd1:    rd_val = cfg_q[15:8];
      7'd2:    rd_val = cfg_q[23:16];
      7'd3:    rd_val = cfg_q[31:24];
      7'd4:    rd_val = status_in;
      7'd5:    rd_val = fcnt_q;
      default: rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rd_d    = rd_q;
    miso_d  = miso_q;
    cfg_d   = cfg_q;
    fcnt_d  = fcnt_q;
    err_d   = err_q;
    if (cs_fall) begin
      state_d = ena ? S_SHIFT : S_IDLE;
      cnt_d   = 5'd0;
      rd_d    = 1'b0;
      miso_d  = 1'b0;
    end else if (state_q == S_SHIFT) begin
      if (cs_rise || !ena) begin
        // leaving SHIFT needs a new cs_n fall to re-enter
        state_d = S_IDLE;
        rd_d    = 1'b0;
        miso_d  = 1'b0;
        if (mid) err_d = 1'b1;
      end else if (sclk_rise && cnt_q != 5'd16) begin
        rx_d  = word[14:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd7 && !word[7]) begin
          tx_d = rd_val;
          rd_d = 1'b1;
        end
        if (cnt_q == 5'd15) begin
          fcnt_d = fcnt_q + 8'd1;
          if (word[15]) begin
            unique case (word[14:8])
              7'd0:    cfg_d[7:0]   = word[7:0];
              7'd1:    cfg_d[15:8]  = word[7:0];
              7'd2:    cfg_d[23:16] = word[7:0];
              7'd3:    cfg_d[31:24] = word[7:0];
              7'd7:    err_d        = 1'b0;
              default: ;
            endcase
          end
        end
      end else if (sclk_fall && rd_q) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= 3'b000;
      cs_q    <= 3'b111;
      mosi_q  <= 2'b00;
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      rx_q    <= 15'd0;
      tx_q    <= 8'd0;
      rd_q    <= 1'b0;
      miso_q  <= 1'b0;
      cfg_q   <= 32'd0;
      fcnt_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      cs_q    <= {cs_q[1:0], cs_n};
      mosi_q  <= {mosi_q[0], mosi};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      miso_q  <= miso_d;
      cfg_q   <= cfg_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  assign miso_oe   = ~cs_q[1] & ena;
  assign miso      = miso_q & miso_oe;
  assign cfg       = cfg_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder.
// Read data goes through a scoreboard queue; cfg/count come from a model.
module tb_spi_reg_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [31:0] cfg;
  logic [7:0]  status_in = 8'h00;
  logic        frame_err;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  logic [7:0]  exp_fcnt = 8'd0;
  logic [31:0] exp_cfg = 32'd0;
  logic        oe_all, oe_any, pre_zero;
  logic [7:0]  dummy;
  logic [15:0] wv;

  always #5 clk = ~clk;

  spi_reg_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .cfg       (cfg),
    .status_in (status_in),
    .frame_err (frame_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] w,
                           input int n,
                           output logic [7:0] rd);
    rd = 8'h00;
    for (int k = 0; k < n; k++) begin
      mosi = w[15-k];
      wait_clk(HALF);
      if (k >= 8) rd = {rd[6:0], miso};
      else if (miso !== 1'b0) pre_zero = 1'b0;
      if (miso_oe !== 1'b1) oe_all = 1'b0;
      if (miso_oe !== 1'b0) oe_any = 1'b1;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] w,
                       output logic [7:0] rd);
    oe_all   = 1'b1;
    oe_any   = 1'b0;
    pre_zero = 1'b1;
    cs_n = 1'b0;
    wait_clk(4);
    send_bits(w, 16, rd);
    wait_clk(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic wr(input logic [6:0] a,
                    input logic [7:0] d);
    logic [7:0] rd;
    frame({1'b1, a, d}, rd);
    exp_fcnt++;
    if (a < 7'd4) exp_cfg[int'(a)*8 +: 8] = d;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [6:0] a,
                        input logic [7:0] exp);
    logic [7:0] got, e;
    sb.push_back(exp);
    frame({1'b0, a, 8'h00}, got);
    exp_fcnt++;
    e = sb.pop_front();
    chk(tag, {24'd0, got}, {24'd0, e});
    chk({tag, "_oe"}, {31'd0, oe_all}, 32'd1);
    chk({tag, "_pre0"}, {31'd0, pre_zero}, 32'd1);
  endtask

  initial begin
    wait_clk(3);
    chk("rst_cfg", cfg, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_oe", {31'd0, miso_oe}, 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    wr(7'd1, 8'h5A);
    chk("wr1_cfg", cfg, 32'h0000_5A00);
    chk("wr1_err", {31'd0, frame_err}, 32'd0);
    rd_chk("rd_a1", 7'd1, 8'h5A);
    chk("rd_a1_cfg", cfg, 32'h0000_5A00);
    rd_chk("rd_fcnt2", 7'd5, 8'd2);

    status_in = 8'hC3;
    rd_chk("rd_stat", 7'd4, 8'hC3);
    rd_chk("rd_a9", 7'd9, 8'h00);
    wr(7'd4, 8'hFF);
    chk("wr4_cfg", cfg, exp_cfg);

    cs_n = 1'b0;
    wait_clk(4);
    send_bits({1'b1, 7'd0, 8'h11}, 10, dummy);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(8);
    chk("abort_cfg", cfg, exp_cfg);
    chk("abort_err", {31'd0, frame_err}, 32'd1);
    rd_chk("abort_fcnt", 7'd5, exp_fcnt);
    rd_chk("rd_a7", 7'd7, 8'h00);
    chk("rd_a7_err", {31'd0, frame_err}, 32'd1);
    wr(7'd7, 8'h00);
    chk("clr_err", {31'd0, frame_err}, 32'd0);

    cs_n = 1'b0;
    wait_clk(6);
    cs_n = 1'b1;
    wait_clk(8);
    chk("cs0_err", {31'd0, frame_err}, 32'd0);

    ena = 1'b0;
    frame({1'b1, 7'd2, 8'h77}, dummy);
    chk("dis_cfg", cfg, exp_cfg);
    chk("dis_oe", {31'd0, oe_any}, 32'd0);
    ena = 1'b1;
    rd_chk("dis_fcnt", 7'd5, exp_fcnt);

    wv = {1'b1, 7'd2, 8'h33};
    cs_n = 1'b0;
    wait_clk(4);
    send_bits(wv, 5, dummy);
    ena = 1'b0;
    wait_clk(2 * HALF);
    ena = 1'b1;
    wv = wv << 5;
    send_bits(wv, 11, dummy);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(8);
    chk("enadrop_cfg", cfg, exp_cfg);
    chk("enadrop_err", {31'd0, frame_err}, 32'd1);
    rd_chk("enadrop_fcnt", 7'd5, exp_fcnt);
    wr(7'd7, 8'h00);
    chk("clr_err2", {31'd0, frame_err}, 32'd0);

    for (int i = 0; i < 256; i++) wr(7'd3, 8'(i));
    chk("loop_cfg", cfg, exp_cfg);
    rd_chk("fcnt_wrap", 7'd5, exp_fcnt);

    cs_n = 1'b0;
    wait_clk(4);
    send_bits({1'b1, 7'd2, 8'hAA}, 12, dummy);
    rst_n = 1'b0;
    wait_clk(3);
    chk("mrst_cfg", cfg, 32'd0);
    chk("mrst_err", {31'd0, frame_err}, 32'd0);
    chk("mrst_miso", {31'd0, miso}, 32'd0);
    chk("mrst_oe", {31'd0, miso_oe}, 32'd0);
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(8);
    chk("post_err", {31'd0, frame_err}, 32'd0);
    exp_cfg  = 32'd0;
    exp_fcnt = 8'd0;
    wr(7'd2, 8'h66);
    chk("post_cfg", cfg, 32'h0066_0000);
    rd_chk("post_fcnt", 7'd5, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
